// File: rtl/retire_stage_pkg.sv
// Shared definitions for the retire slice.
//   `PR  : physical register index width (128 physical registers)
//   `ROB : reorder buffer depth
//   ROB_ENTRY_PACKET : one ROB slot as presented on the retire port
//   RETIRE_WAYS / NUM_ARCH_REGS : default retire width and architectural register count
//   ST_RUN / ST_RECOVER : retire-stage FSM encodings
//   count_accepted() : number of set bits in an accepted-way mask
`ifndef PR
`define PR 7
`endif
`ifndef ROB
`define ROB 32
`endif

package retire_stage_pkg;

  localparam int RETIRE_WAYS   = 3;
  localparam int NUM_ARCH_REGS = 32;

  typedef struct packed {
    logic           valid;
    logic           completed;
    logic [4:0]     arch_reg;
    logic [`PR-1:0] Tnew;
    logic [`PR-1:0] Told;
  } ROB_ENTRY_PACKET;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  function automatic logic [1:0] count_accepted(input logic [RETIRE_WAYS-1:0] mask);
    int n;
    n = 0;
    for (int k = 0; k < RETIRE_WAYS; k++) begin
      if (mask[k]) n++;
    end
    return 2'(n);
  endfunction

endpackage

// File: rtl/retire_stage_if.sv
// Retire-stage bus: ROB retire port and squash request in, free-list return,
// committed map and perf counters out.
//   master : ROB / recovery controller side (drives retire_entry, squash)
//   slave  : retire_stage side (drives everything else)
`ifndef PR
`define PR 7
`endif

interface retire_stage_if
  import retire_stage_pkg::*;
#(
  parameter int WAYS      = RETIRE_WAYS,
  parameter int ARCH_REGS = NUM_ARCH_REGS
);

  ROB_ENTRY_PACKET [WAYS-1:0]                retire_entry;
  logic                                      squash;
  logic            [WAYS-1:0]                free_valid;
  logic            [WAYS-1:0][`PR-1:0]       free_preg;
  logic            [ARCH_REGS-1:0][`PR-1:0]  arch_map;
  logic                                      recover_valid;
  logic            [1:0]                     retire_num;
  logic            [31:0]                    retired_count;

  modport master (
    output retire_entry, squash,
    input  free_valid, free_preg, arch_map, recover_valid, retire_num, retired_count
  );

  modport slave (
    input  retire_entry, squash,
    output free_valid, free_preg, arch_map, recover_valid, retire_num, retired_count
  );

endinterface

// File: rtl/retire_stage_amt_regfile.sv
// Architectural map table: ARCH_REGS entries of `PR bits.
//   clock, reset : clock and synchronous active-high reset (entry i resets to i)
//   wr_en/wr_addr/wr_data : WAYS write ports; a higher-numbered port wins
//                           when several hit the same entry in one cycle
//   rd_map : every entry, read out in parallel
// The caller is responsible for never writing entry 0.
`ifndef PR
`define PR 7
`endif

module amt_regfile
  import retire_stage_pkg::*;
#(
  parameter  int WAYS      = RETIRE_WAYS,
  parameter  int ARCH_REGS = NUM_ARCH_REGS,
  localparam int AREG_W    = $clog2(ARCH_REGS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WAYS-1:0]                 wr_en,
  input  logic [WAYS-1:0][AREG_W-1:0]     wr_addr,
  input  logic [WAYS-1:0][`PR-1:0]        wr_data,
  output logic [ARCH_REGS-1:0][`PR-1:0]   rd_map
);

  genvar gi;
  generate
    for (gi = 0; gi < ARCH_REGS; gi++) begin : g_entry
      logic [`PR-1:0] entry_reg;
      logic [`PR-1:0] entry_next;

      // Scanning ports oldest-first lets the youngest matching write win.
      always_comb begin
        entry_next = entry_reg;
        for (int w = 0; w < WAYS; w++) begin
          if (wr_en[w] && (wr_addr[w] == AREG_W'(gi))) begin
            entry_next = wr_data[w];
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          entry_reg <= `PR'(gi);
        end else begin
          entry_reg <= entry_next;
        end
      end

      assign rd_map[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/retire_stage.sv
// Retire stage: commits up to WAYS ROB entries per cycle into the
// architectural map table, returns superseded physical registers (Told) to
// the free list, and flags one cycle where arch_map is the precise state for
// rename-table recovery after a squash.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : retire_entry/squash in; free_valid, free_preg, arch_map,
//                  recover_valid, retire_num, retired_count out (all registered)
`ifndef PR
`define PR 7
`endif

module retire_stage
  import retire_stage_pkg::*;
#(
  parameter  int WAYS      = RETIRE_WAYS,
  parameter  int ARCH_REGS = NUM_ARCH_REGS,
  localparam int AREG_W    = $clog2(ARCH_REGS)
) (
  input  logic           clock,
  input  logic           reset,
  retire_stage_if.slave  bus
);

  logic [WAYS-1:0]              valid_in;
  logic [WAYS-1:0]              accepted;
  logic [WAYS-1:0]              write_en;
  logic [WAYS-1:0][AREG_W-1:0]  wr_addr;
  logic [WAYS-1:0][`PR-1:0]     wr_data;
  logic [WAYS-1:0][`PR-1:0]     free_preg_next;
  logic [1:0]                   retire_num_next;

  logic [WAYS-1:0]              free_valid_reg;
  logic [WAYS-1:0][`PR-1:0]     free_preg_reg;
  logic [1:0]                   retire_num_reg;
  logic [31:0]                  retired_count_reg;
  logic [0:0]                   state_reg;
  logic [0:0]                   state_next;

  // A way retires only if it and every older way are valid; anything past the
  // first hole is dropped so commit order is never violated.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign valid_in[gi] = bus.retire_entry[gi].valid;

      if (gi == 0) begin : g_oldest
        assign accepted[gi] = valid_in[gi];
      end else begin : g_younger
        assign accepted[gi] = accepted[gi-1] & valid_in[gi];
      end

      // arch_reg 0 is hardwired: no map write and nothing to free.
      assign write_en[gi]       = accepted[gi] && (bus.retire_entry[gi].arch_reg != '0);
      assign wr_addr[gi]        = AREG_W'(bus.retire_entry[gi].arch_reg);
      assign wr_data[gi]        = bus.retire_entry[gi].Tnew;
      assign free_preg_next[gi] = write_en[gi] ? bus.retire_entry[gi].Told : '0;
    end
  endgenerate

  assign retire_num_next = count_accepted(accepted);

  amt_regfile #(
    .WAYS      (WAYS),
    .ARCH_REGS (ARCH_REGS)
  ) u_amt (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (write_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_map  (bus.arch_map)
  );

  // Retirements in the squash cycle are older than the squash point, so they
  // land in the map on the same edge that enters RECOVER; recover_valid and
  // the post-retire map therefore appear together.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:     state_next = bus.squash ? ST_RECOVER : ST_RUN;
      ST_RECOVER: state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_RUN;
      free_valid_reg    <= '0;
      free_preg_reg     <= '0;
      retire_num_reg    <= '0;
      retired_count_reg <= '0;
    end else begin
      state_reg         <= state_next;
      free_valid_reg    <= write_en;
      free_preg_reg     <= free_preg_next;
      retire_num_reg    <= retire_num_next;
      retired_count_reg <= retired_count_reg + {30'd0, retire_num_next};
    end
  end

  assign bus.free_valid    = free_valid_reg;
  assign bus.free_preg     = free_preg_reg;
  assign bus.retire_num    = retire_num_reg;
  assign bus.retired_count = retired_count_reg;
  assign bus.recover_valid = (state_reg == ST_RECOVER);

`ifndef SYNTHESIS
  // Protocol checks on the ROB side; they never change behaviour.
  always @(posedge clock) begin
    if (!reset) begin
      assert ((valid_in & ~accepted) == '0)
        else $warning("retire_stage: non-contiguous retire valid mask %b", valid_in);
      for (int k = 0; k < WAYS; k++) begin
        assert (!accepted[k] || bus.retire_entry[k].completed)
          else $warning("retire_stage: way %0d retired without completed", k);
      end
      assert (state_reg != ST_RECOVER || valid_in == '0)
        else $warning("retire_stage: retire valid during recovery cycle");
    end
  end
`endif

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- Consumer end of the ROB retire interface: takes up to 3 retiring ROB_ENTRY_PACKETs per cycle from the ROB.
- Commits them to the architectural map table (AMT) and returns the superseded physical registers (Told) to the free list.
- Provides the precise architectural mapping for squash recovery, plus a retired-instruction counter for perf and debug.
- Sits between the ROB retire port and the free list / rename map table.

Parameters:
- WAYS, 3, retire width; must match the ROB retire width.
- ARCH_REGS, 32, number of architectural registers (5-bit arch_reg).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- retire_entry  input  [WAYS-1:0] ROB_ENTRY_PACKET  retiring entries from the ROB; way 0 is oldest; .valid marks a retiring slot
- squash  input  1  mispredict/exception recovery request
- free_valid  output  [WAYS-1:0]  per-way Told return strobe to the free list
- free_preg  output  [WAYS-1:0][`PR-1:0]  Told being returned
- arch_map  output  [ARCH_REGS-1:0][`PR-1:0]  current committed AMT
- recover_valid  output  1  one-cycle strobe: arch_map is the precise state to copy into the rename map table
- retire_num  output  [1:0]  number of entries committed last cycle
- retired_count  output  [31:0]  total committed instructions since reset

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - arch_map[i] = i for all i.
  - free_valid = 0, free_preg = 0, recover_valid = 0, retire_num = 0, retired_count = 0.
  - FSM = RUN.
- Accepted set:
  - Way k is accepted iff retire_entry[k].valid and all lower ways are valid.
  - Non-contiguous valid bits are protocol errors; ways after the first invalid way are ignored, and a simulation assertion fires.
  - retire_entry[k].completed must be 1 for accepted ways (assertion only; no functional effect).
- Latency: all outputs are registered; an input retired at edge N is visible after edge N.
- AMT update, for each accepted way in order 0..WAYS-1:
  - If arch_reg != 0, arch_map[arch_reg] <= Tnew.
  - Same arch_reg in several ways in one cycle: the highest (youngest) way wins.
  - arch_reg == 0: no AMT write.
- Free return:
  - free_valid[k] = 1 and free_preg[k] = Told for accepted ways with arch_reg != 0.
  - Way k unaccepted or arch_reg == 0: free_valid[k] = 0 and free_preg[k] = 0.
  - Within one cycle, the Told of a younger way equals the Tnew of an older way when both target the same arch_reg. That Told is still returned; it is correct because the older mapping is dead at commit.
- Counters:
  - retire_num = number of accepted ways.
  - retired_count += retire_num, wrapping modulo 2^32.
- FSM:
  - RUN: squash=1 -> RECOVER. Retirements in the same cycle as squash are applied first (they are older than the squash point).
  - RECOVER (exactly 1 cycle): recover_valid = 1 and arch_map holds the final post-retire state. Next state is RUN unconditionally.
  - squash held high: the FSM alternates RUN/RECOVER, so recover_valid pulses every other cycle. This is legal, but the controller pulses squash for 1 cycle.
  - Retire inputs during RECOVER are still processed. The ROB guarantees they are all invalid after a squash; an assertion checks this.
- Reset mid-operation (any state): immediate return to the reset values above. Pending free_valid strobes are dropped; the free list resets simultaneously.

Decomposition:
- ROB_ENTRY_PACKET, `PR, `ROB and the WAYS constant live in the shared sys_defs package; no new typedefs.
- One natural sub-module: amt_regfile, a ARCH_REGS x `PR register file with WAYS priority-ordered write ports, identity reset and a full parallel read-out.
- FSM, counters and free-return logic stay in retire_stage.

Test Plan:
- Reset, no input -> arch_map[i] == i for all i, retired_count == 0, free_valid == 0, recover_valid == 0.
- Retire 3 entries {Tnew=40,Told=1,arch=1}, {41,2,2}, {42,3,3} -> next cycle arch_map[1..3] = 40,41,42; free_valid = 3'b111; free_preg = {3,2,1}; retire_num = 3; retired_count = 3.
- Same-reg collision: way0 {50,5,5}, way1 {51,50,5} -> arch_map[5] = 51; free_preg[0] = 5, free_preg[1] = 50; free_valid = 3'b011.
- arch_reg 0 plus gap: way0 {60,0,0} valid, way1 invalid, way2 {61,7,7} valid -> no AMT change; free_valid = 0; retire_num = 1; way2 ignored; assertion fires.
- Squash with a same-cycle retire of {70,8,8} -> next cycle recover_valid = 1 with arch_map[8] = 70; following cycle recover_valid = 0.
- Reset asserted in the RECOVER cycle after several retirements -> identity map, counters 0, recover_valid = 0 the next cycle.
